// File: rtl/bnn_output_layer.sv
// rtl/bnn_output_layer.sv - binarized output layer: XNOR-popcount per neuron, threshold and argmax
module bnn_output_layer #(
  parameter int IN_W    = 8,
  parameter int NUM_OUT = 4,
  parameter int THRESH  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_vec,
  input  logic               wload_en,
  input  logic [3:0]         wload_nib,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_act,
  output logic [1:0]         out_class,
  output logic [3:0]         out_score,
  output logic               busy
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t            state, state_next;
  logic [IN_W-1:0]   w [NUM_OUT];
  logic [IN_W-1:0]   vec;
  logic [IN_W-1:0]   match;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  wptr;
  logic              nib_tog;
  logic [3:0]        nib_lo;
  logic [3:0]        score;
  logic              last_idx;

  function automatic logic [IN_W-1:0] default_weight(input int k);
    case (k)
      0:       return IN_W'(8'hF9);
      1:       return IN_W'(8'h62);
      2:       return IN_W'(8'hF7);
      3:       return IN_W'(8'h0F);
      default: return '0;
    endcase
  endfunction

  // XNOR-popcount of the captured vector against the neuron selected by idx
  always_comb begin
    match = ~(vec ^ w[idx]);
    score = '0;
    for (int i = 0; i < IN_W; i++) begin
      score = score + 4'(match[i]);
    end
  end

  assign last_idx = (idx == IDX_W'(NUM_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = ~wload_en;
        if (in_valid && !wload_en) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (last_idx) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // out_class/out_score double as the running argmax while computing
  always_ff @(posedge clk) begin
    if (reset) begin
      out_act   <= '0;
      out_class <= '0;
      out_score <= '0;
      idx       <= '0;
      wptr      <= '0;
      nib_tog   <= 1'b0;
      nib_lo    <= '0;
      vec       <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        w[k] <= default_weight(k);
      end
    end else begin
      case (state)
        IDLE: begin
          if (wload_en) begin
            if (!nib_tog) begin
              nib_lo  <= wload_nib;
              nib_tog <= 1'b1;
            end else begin
              w[wptr] <= IN_W'({wload_nib, nib_lo});
              wptr    <= (wptr == IDX_W'(NUM_OUT - 1)) ? '0 : wptr + 1'b1;
              nib_tog <= 1'b0;
            end
          end else if (in_valid) begin
            vec       <= in_vec;
            idx       <= '0;
            out_act   <= '0;
            out_class <= '0;
            out_score <= '0;
          end
        end
        COMPUTE: begin
          out_act[idx] <= (score >= 4'(THRESH));
          // strict compare keeps the lower index on ties
          if (idx == '0 || score > out_score) begin
            out_class <= 2'(idx);
            out_score <= score;
          end
          idx <= last_idx ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_output_layer.sv
// tb/tb_bnn_output_layer.sv - directed self-checking bench for bnn_output_layer
module tb_bnn_output_layer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       wload_en;
  logic [3:0] wload_nib;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_act;
  logic [1:0] out_class;
  logic [3:0] out_score;
  logic       busy;

  int passes = 0;
  int total  = 0;
  int cnt;

  bnn_output_layer #(.IN_W(8), .NUM_OUT(4), .THRESH(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .wload_en  (wload_en),
    .wload_nib (wload_nib),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .out_class (out_class),
    .out_score (out_score),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_pair(input logic [3:0] lo, input logic [3:0] hi);
    wload_en  = 1'b1;
    wload_nib = lo;
    tick();
    wload_nib = hi;
    tick();
    wload_en  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_vec(input string tag, input logic [7:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start_cnt);
    cnt = start_cnt;
    while (out_valid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd4);
  endtask

  task automatic chk_result(input string tag, input logic [3:0] act,
                            input logic [1:0] cls, input logic [3:0] sc);
    chk({tag, "_act"},   32'(out_act),   32'(act));
    chk({tag, "_class"}, 32'(out_class), 32'(cls));
    chk({tag, "_score"}, 32'(out_score), 32'(sc));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_busy"},  32'(busy),      32'd0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] v, input logic [3:0] act,
                         input logic [1:0] cls, input logic [3:0] sc);
    start_vec(tag, v);
    wait_done(tag, 0);
    chk_result(tag, act, cls, sc);
    release_out(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    wload_en  = 1'b0;
    wload_nib = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_act",      32'(out_act),   32'd0);
    chk("rst_class",    32'(out_class), 32'd0);
    chk("rst_score",    32'(out_score), 32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_in_ready", 32'(in_ready),  32'd1);

    // default weights, all-ones vector, with per-cycle latency probing
    start_vec("ff", 8'hFF);
    chk("ff_busy", 32'(busy), 32'd1);
    chk("ff_in_ready_busy", 32'(in_ready), 32'd0);
    wait_done("ff", 0);
    chk_result("ff", 4'b0101, 2'd2, 4'd7);
    release_out("ff");

    // default weights, all-zeros vector, then hold in DONE
    start_vec("zero", 8'h00);
    wait_done("zero", 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_result("hold", 4'b0000, 2'd1, 4'd5);
      chk("hold_valid",    32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready),  32'd0);
      chk("hold_busy",     32'(busy),      32'd1);
    end
    in_vec    = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("done_exit_busy",  32'(busy),      32'd0);
    chk("done_exit_valid", 32'(out_valid), 32'd0);
    tick();
    chk("done_no_capture", 32'(busy), 32'd0);

    // nibble load A then 5 -> w0 = 8'h5A; loads during COMPUTE ignored
    do_reset();
    load_pair(4'hA, 4'h5);
    start_vec("w5a", 8'h5A);
    wload_en  = 1'b1;
    wload_nib = 4'hA;
    tick();
    wload_nib = 4'h5;
    tick();
    wload_en  = 1'b0;
    wait_done("w5a", 2);
    chk_result("w5a", 4'b0001, 2'd0, 4'd8);
    release_out("w5a");
    run_vec("w5a_again", 8'h5A, 4'b0001, 2'd0, 4'd8);

    // all weights 8'hAA -> tie resolves to neuron 0
    do_reset();
    for (int i = 0; i < 4; i++) load_pair(4'hA, 4'hA);
    run_vec("aa", 8'hAA, 4'b1111, 2'd0, 4'd8);

    // load beats in_valid; 5th pair wraps to w0 = 8'h55
    wload_en  = 1'b1;
    wload_nib = 4'h5;
    in_vec    = 8'hAA;
    in_valid  = 1'b1;
    #1;
    chk("load_wins_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("load_wins_busy", 32'(busy), 32'd0);
    tick();
    wload_en = 1'b0;
    run_vec("wrap", 8'hAA, 4'b1110, 2'd1, 4'd8);

    // reset while computing idx 2
    start_vec("abort", 8'hAA);
    tick();
    tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_act",   32'(out_act),   32'd0);
    chk("abort_score", 32'(out_score), 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_valid_after", 32'(out_valid), 32'd0);
    run_vec("post_abort", 8'hFF, 4'b0101, 2'd2, 4'd7);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
